// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared data-cache definitions used by the flush sequencer.
// Holds geometry/width constants, tag bit positions, the flush FSM state
// enum, the write-back payload struct and the write-back address helper.
package dcache_flush_ctrl_pkg;

  localparam int unsigned NUM_SETS      = 16;
  localparam int unsigned NUM_WAYS      = 2;
  localparam int unsigned IDX_W         = $clog2(NUM_SETS);
  localparam int unsigned WAY_W         = $clog2(NUM_WAYS);
  localparam int unsigned PTR_W         = IDX_W + WAY_W;
  localparam int unsigned TAG_W         = 25;
  localparam int unsigned ATAG_W        = 23;
  localparam int unsigned LINE_W        = 256;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned OFS_W         = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W         = 6;
  localparam int unsigned TAG_VALID_BIT = 24;
  localparam int unsigned TAG_DIRTY_BIT = 23;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EVAL,
    WB,
    CLR,
    DONE
  } flush_state_e;

  // Write-back payload presented on the memory port
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wb_req_t;

  // Line base address: {address tag, set index, zero byte offset}
  function automatic logic [ADDR_W-1:0] wb_addr(input logic [ATAG_W-1:0] atag,
                                                input logic [IDX_W-1:0]  idx);
    return {atag, idx, OFS_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: hardware flush sequencer for the 2-way, 16-set data cache.
// Walks every SRAM entry (way 0 sets 0..15, then way 1 sets 0..15), writes
// each valid+dirty line back to memory and strobes a dirty-bit clear.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_req_i           level request, accepted only when cache_idle_i
//   cache_idle_i          dcache controller idle, no miss in flight
//   busy_o                flush owns the SRAM scan port and memory port
//   flush_done_o          one-cycle completion pulse
//   wb_count_o            lines written back in the last/current flush
//   sram_idx_o/sram_way_o scan pointer
//   sram_tag_i/sram_data_i combinational SRAM read at the scan pointer
//   sram_clr_o            one-cycle clear strobe at the scan pointer
//   mem_*                 enable/write/ack memory write-back port
//
// Build option: DCACHE_FLUSH_INVALIDATE_EN -- clear strobe also drops valid,
// and valid clean lines get a clear strobe (no write-back, not counted).
module dcache_flush_ctrl
  import dcache_flush_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_req_i,
  input  logic              cache_idle_i,
  output logic              busy_o,
  output logic              flush_done_o,
  output logic [CNT_W-1:0]  wb_count_o,
  output logic [IDX_W-1:0]  sram_idx_o,
  output logic              sram_way_o,
  input  logic [TAG_W-1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              sram_clr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i
);

  flush_state_e     r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_valid;
  logic             r_dirty;
  wb_req_t          r_wb;
  logic             r_busy;
  logic             r_done;
  logic             r_clr;
  logic             r_mem_en;
  logic             r_mem_wr;
  logic [CNT_W-1:0] r_wb_cnt;

  logic w_last;
  logic w_dirty_hit;
  logic w_inv_hit;

  // Pointer is {way, idx}, so the final entry is all ones
  assign w_last      = &r_ptr;
  assign w_dirty_hit = r_valid & r_dirty;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  assign w_inv_hit = r_valid & ~r_dirty;
`else
  assign w_inv_hit = 1'b0;
`endif

  // Flush sequencer with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_dirty  <= 1'b0;
      r_wb     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_clr    <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_wr <= 1'b0;
      r_wb_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush_req_i && cache_idle_i) begin
            r_state  <= SCAN;
            r_busy   <= 1'b1;
            r_ptr    <= '0;
            r_wb_cnt <= '0;
          end
        end
        SCAN: begin
          r_valid   <= sram_tag_i[TAG_VALID_BIT];
          r_dirty   <= sram_tag_i[TAG_DIRTY_BIT];
          r_wb.addr <= wb_addr(sram_tag_i[ATAG_W-1:0], r_ptr[IDX_W-1:0]);
          r_wb.data <= sram_data_i;
          r_state   <= EVAL;
        end
        EVAL: begin
          if (w_dirty_hit) begin
            r_state  <= WB;
            r_mem_en <= 1'b1;
            r_mem_wr <= 1'b1;
          end else if (w_inv_hit) begin
            r_state <= CLR;
            r_clr   <= 1'b1;
          end else if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_wb    <= '0;
          end else begin
            r_ptr   <= r_ptr + PTR_W'(1);
            r_state <= SCAN;
          end
        end
        WB: begin
          // Request held stable until the ack is sampled
          if (mem_ack_i) begin
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            r_clr    <= 1'b1;
            r_state  <= CLR;
          end
        end
        CLR: begin
          // Only lines that went through write-back are counted
          if (r_dirty) begin
            r_wb_cnt <= r_wb_cnt + CNT_W'(1);
          end
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_wb    <= '0;
          end else begin
            r_ptr   <= r_ptr + PTR_W'(1);
            r_state <= SCAN;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign flush_done_o = r_done;
  assign wb_count_o   = r_wb_cnt;
  assign sram_idx_o   = r_ptr[IDX_W-1:0];
  assign sram_way_o   = r_ptr[PTR_W-1];
  assign sram_clr_o   = r_clr;
  assign mem_addr_o   = r_wb.addr;
  assign mem_data_o   = r_wb.data;
  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_wr;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench for dcache_flush_ctrl.
// A timeline model predicts, per cycle after acceptance, which phase the
// flush is in (scan, evaluate, write-back, clear, done) from a snapshot of
// the SRAM contents; a negedge compare process checks every output against
// it. Directed tests add literal expectations for timing and addresses.
`timescale 1ns/1ps
module tb_dcache_flush_ctrl;

  localparam int NENT = 32;
  localparam int K_S  = 0;
  localparam int K_E  = 1;
  localparam int K_W  = 2;
  localparam int K_C  = 3;
  localparam int K_D  = 4;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_req = 1'b0;
  logic         cache_idle = 1'b1;
  logic         busy_o, flush_done_o, sram_way_o, sram_clr_o;
  logic         mem_enable_o, mem_write_o;
  logic         mem_ack = 1'b0;
  logic [5:0]   wb_count_o;
  logic [3:0]   sram_idx_o;
  logic [24:0]  sram_tag;
  logic [255:0] sram_data;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;

  logic [24:0]  tb_tag  [NENT];
  logic [255:0] tb_data [NENT];
  logic [24:0]  snap_tag  [NENT];
  logic [255:0] snap_data [NENT];

  typedef struct { int kind; int ent; } step_t;
  step_t exp_q[$];

  logic [31:0]  log_addr[$];
  logic [255:0] log_data[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  ack_dly = 10;
  int  wb_cyc  = 0;
  int  m_cnt   = 0;
  int  done_cnt = 0;
  logic spur_ack = 1'b0;

  dcache_flush_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_req_i  (flush_req),
    .cache_idle_i (cache_idle),
    .busy_o       (busy_o),
    .flush_done_o (flush_done_o),
    .wb_count_o   (wb_count_o),
    .sram_idx_o   (sram_idx_o),
    .sram_way_o   (sram_way_o),
    .sram_tag_i   (sram_tag),
    .sram_data_i  (sram_data),
    .sram_clr_o   (sram_clr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_ack_i    (mem_ack)
  );

  always #5 clk = ~clk;

  assign sram_tag  = tb_tag[{sram_way_o, sram_idx_o}];
  assign sram_data = tb_data[{sram_way_o, sram_idx_o}];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic step_t mk(input int k, input int e);
    step_t s;
    s.kind = k;
    s.ent  = e;
    return s;
  endfunction

  function automatic logic [31:0] exp_addr(input int p);
    return 32'(snap_tag[p][22:0]) * 32'd512 + 32'(p % 16) * 32'd32;
  endfunction

  // SRAM side effect of the clear strobe
  always @(posedge clk) begin
    if (sram_clr_o) begin
      tb_tag[{sram_way_o, sram_idx_o}][23] = 1'b0;
      if (INV) tb_tag[{sram_way_o, sram_idx_o}][24] = 1'b0;
    end
  end

  // Memory responder: ack during the ack_dly-th cycle of each request
  always @(negedge clk) begin
    if (mem_enable_o) begin
      wb_cyc++;
      mem_ack = (wb_cyc == ack_dly);
      if (mem_ack) begin
        log_addr.push_back(mem_addr_o);
        log_data.push_back(mem_data_o);
      end
    end else begin
      wb_cyc  = 0;
      mem_ack = spur_ack;
    end
  end

  // Timeline model: one step per cycle from the accepting edge on
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].kind == K_C && snap_tag[exp_q[0].ent][24] && snap_tag[exp_q[0].ent][23])
        m_cnt++;
      void'(exp_q.pop_front());
    end else if (flush_req && cache_idle) begin
      m_cnt = 0;
      for (int p = 0; p < NENT; p++) begin
        snap_tag[p]  = tb_tag[p];
        snap_data[p] = tb_data[p];
        exp_q.push_back(mk(K_S, p));
        exp_q.push_back(mk(K_E, p));
        if (tb_tag[p][24] && tb_tag[p][23]) begin
          for (int w = 0; w < ack_dly; w++) exp_q.push_back(mk(K_W, p));
          exp_q.push_back(mk(K_C, p));
        end else if (INV && tb_tag[p][24]) begin
          exp_q.push_back(mk(K_C, p));
        end
      end
      exp_q.push_back(mk(K_D, 0));
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (flush_done_o) done_cnt++;
      chk("wb_count", 256'(wb_count_o), 256'(m_cnt));
      if (exp_q.size() == 0) begin
        chk("idle_busy", 256'(busy_o), 256'd0);
        chk("idle_mem_en", 256'({mem_enable_o, mem_write_o}), 256'd0);
        chk("idle_done_clr", 256'({flush_done_o, sram_clr_o}), 256'd0);
        chk("idle_addr", 256'(mem_addr_o), 256'd0);
        chk("idle_data", mem_data_o, 256'd0);
      end else begin
        chk("busy", 256'(busy_o), 256'd1);
        chk("mem_en", 256'(mem_enable_o), 256'(exp_q[0].kind == K_W));
        chk("mem_wr", 256'(mem_write_o), 256'(exp_q[0].kind == K_W));
        chk("sram_clr", 256'(sram_clr_o), 256'(exp_q[0].kind == K_C));
        chk("done", 256'(flush_done_o), 256'(exp_q[0].kind == K_D));
        if (exp_q[0].kind == K_S || exp_q[0].kind == K_C)
          chk("pointer", 256'({sram_way_o, sram_idx_o}), 256'(exp_q[0].ent));
        if (exp_q[0].kind == K_W) begin
          chk("wb_addr", 256'(mem_addr_o), 256'(exp_addr(exp_q[0].ent)));
          chk("wb_data", mem_data_o, snap_data[exp_q[0].ent]);
        end
        if (exp_q[0].kind == K_D) begin
          chk("done_addr", 256'(mem_addr_o), 256'd0);
          chk("done_data", mem_data_o, 256'd0);
        end
      end
    end
  end

  task automatic wait_done(input int max_cyc, output int edges);
    edges = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      if (flush_done_o) begin
        edges = k;
        break;
      end
    end
    if (edges < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no flush_done_o within %0d cycles", max_cyc);
    end
  endtask

  // Raise the request for one edge; that edge is the accepting edge
  task automatic run_flush(input int max_cyc, output int edges);
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    wait_done(max_cyc, edges);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int e;
  int e2;

  initial begin
    for (int p = 0; p < NENT; p++) begin
      tb_tag[p]  = 25'h0;
      tb_data[p] = {8{32'(p) * 32'h0101_0101}};
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", 256'(busy_o), 256'd0);
    chk("rst_wb_count", 256'(wb_count_o), 256'd0);
    chk("rst_ptr", 256'({sram_way_o, sram_idx_o}), 256'd0);
    chk("rst_mem_en", 256'(mem_enable_o), 256'd0);

    // Clean cache: done 64 edges after acceptance, no writes
    run_flush(200, e);
    chk("clean_done_edge", 256'(e), 256'd64);
    chk("clean_wb_count", 256'(wb_count_o), 256'd0);
    chk("clean_writes", 256'(log_addr.size()), 256'd0);
    chk("clean_busy_after", 256'(busy_o), 256'd0);

    // Two dirty lines, ack on the 10th WB cycle each
    tb_tag[1]   = 25'h1800000;
    tb_data[1]  = {8{32'hECFA_5A3C}};
    tb_tag[31]  = 25'h1800001;
    tb_data[31] = {8{32'h1357_9BDF}};
    ack_dly = 10;
    run_flush(300, e);
    chk("dirty_done_edge", 256'(e), 256'd86);
    chk("dirty_wb_count", 256'(wb_count_o), 256'd2);
    chk("dirty_nwrites", 256'(log_addr.size()), 256'd2);
    chk("dirty_addr0", 256'(log_addr[0]), 256'h20);
    chk("dirty_data0", log_data[0], {8{32'hECFA_5A3C}});
    chk("dirty_addr1", 256'(log_addr[1]), 256'h3E0);
    chk("dirty_data1", log_data[1], {8{32'h1357_9BDF}});
    chk("dirty_bits_cleared", 256'({tb_tag[1][23], tb_tag[31][23]}), 256'd0);
    chk("valid_bits_after", 256'({tb_tag[1][24], tb_tag[31][24]}), INV ? 256'd0 : 256'd3);

    // Request gated by cache_idle
    cache_idle = 1'b0;
    @(posedge clk); #1 flush_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("gated_busy", 256'(busy_o), 256'd0);
    end
    cache_idle = 1'b1;
    @(posedge clk); #1;
    chk("gated_accept", 256'(busy_o), 256'd1);
    flush_req = 1'b0;
    wait_done(200, e);
    chk("gated_done_edge", 256'(e), 256'd64);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a write-back
    log_addr.delete();
    log_data.delete();
    tb_tag[0]  = 25'h1800007;
    tb_data[0] = {4{64'hA5A5_0F0F_C3C3_7E7E}};
    ack_dly = 50;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_enable_o) break;
      @(posedge clk); #1;
    end
    chk("rst_wb_reached", 256'(mem_enable_o), 256'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async_mem_en", 256'({mem_enable_o, mem_write_o}), 256'd0);
    chk("async_busy", 256'({busy_o, flush_done_o, sram_clr_o}), 256'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_wb_count_zero", 256'(wb_count_o), 256'd0);
    chk("rst_dirty_kept", 256'(tb_tag[0][23]), 256'd1);
    chk("rst_no_write", 256'(log_addr.size()), 256'd0);
    ack_dly = 3;
    run_flush(200, e);
    chk("post_rst_done_edge", 256'(e), 256'd68);
    chk("post_rst_addr", 256'(log_addr[0]), 256'hE00);
    chk("post_rst_data", log_data[0], {4{64'hA5A5_0F0F_C3C3_7E7E}});
    chk("post_rst_wb_count", 256'(wb_count_o), 256'd1);
    chk("post_rst_dirty", 256'(tb_tag[0][23]), 256'd0);

    // Request pulsed while busy, spurious ack while scanning
    log_addr.delete();
    log_data.delete();
    tb_tag[9]  = 25'h1800005;
    tb_data[9] = {16{16'hBEEF}};
    ack_dly  = 2;
    done_cnt = 0;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_ack = 1'b0;
    flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    wait_done(200, e2);
    chk("spur_done_edge", 256'(e2 + 4), 256'd67);
    repeat (6) @(posedge clk);
    #1;
    chk("spur_one_flush", 256'(done_cnt), 256'd1);
    chk("spur_busy_after", 256'(busy_o), 256'd0);
    chk("spur_nwrites", 256'(log_addr.size()), 256'd1);
    chk("spur_addr", 256'(log_addr[0]), 256'hB20);

    // One valid clean line
    log_addr.delete();
    log_data.delete();
    tb_tag[12] = 25'h1000033;
    run_flush(200, e);
    chk("vclean_done_edge", 256'(e), INV ? 256'd65 : 256'd64);
    chk("vclean_no_write", 256'(log_addr.size()), 256'd0);
    chk("vclean_wb_count", 256'(wb_count_o), 256'd0);
    chk("vclean_valid", 256'(tb_tag[12][24]), INV ? 256'd0 : 256'd1);
    begin
      int nvalid = 0;
      for (int p = 0; p < NENT; p++) nvalid += int'(tb_tag[p][24]);
      chk("final_valid_count", 256'(nvalid), INV ? 256'd0 : 256'd5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL global_timeout: bench did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
